// File: rtl/midi_msg_parser.sv
// midi_msg_parser: frames MIDI messages from a UART byte stream (running
// status, SysEx skipping, channel filtering, interleaved real-time bytes)
// and queues completed messages in a small FIFO with a valid/ready handshake.
// Optional feature macro: MIDI_PARSER_REALTIME_EN (queue real-time bytes as
// single-byte messages instead of dropping them).
module midi_msg_parser #(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_byte,
  output logic                          msg_valid,
  input  logic                          msg_ready,
  output logic [7:0]                    msg_status,
  output logic [7:0]                    msg_data1,
  output logic [7:0]                    msg_data2,
  output logic [1:0]                    msg_len,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  state_t     state, state_nxt;
  logic [7:0] cur_status, cur_status_nxt;
  logic [7:0] data1_q, data1_nxt;
  logic       need2, need2_nxt;

  logic       push_req;
  logic [7:0] push_status, push_d1, push_d2;
  logic [1:0] push_len;

  logic [25:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, push_ok;

  // Byte decode: next parser state and the message completed by this byte
  always_comb begin
    state_nxt      = state;
    cur_status_nxt = cur_status;
    data1_nxt      = data1_q;
    need2_nxt      = need2;
    push_req       = 1'b0;
    push_status    = cur_status;
    push_d1        = 8'h00;
    push_d2        = 8'h00;
    push_len       = 2'd0;
    if (rx_valid) begin
      if (rx_byte[7:3] == 5'b11111) begin
        // real-time bytes never disturb the parser
`ifdef MIDI_PARSER_REALTIME_EN
        push_req    = 1'b1;
        push_status = rx_byte;
        push_len    = 2'd1;
`endif
      end else if (rx_byte[7]) begin
        if (state == SYSEX && rx_byte == 8'hF7) begin
          state_nxt = IDLE;
        end else if (rx_byte < 8'hF0) begin
          cur_status_nxt = rx_byte;
          need2_nxt      = !(rx_byte[7:4] == 4'hC || rx_byte[7:4] == 4'hD);
          state_nxt      = WAIT_D1;
        end else begin
          case (rx_byte)
            8'hF0: state_nxt = SYSEX;
            8'hF1, 8'hF3: begin
              cur_status_nxt = rx_byte;
              need2_nxt      = 1'b0;
              state_nxt      = WAIT_D1;
            end
            8'hF2: begin
              cur_status_nxt = rx_byte;
              need2_nxt      = 1'b1;
              state_nxt      = WAIT_D1;
            end
            8'hF6: begin
              push_req    = 1'b1;
              push_status = rx_byte;
              push_len    = 2'd1;
              state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end else begin
        case (state)
          WAIT_D1: begin
            if (need2) begin
              data1_nxt = rx_byte;
              state_nxt = WAIT_D2;
            end else begin
              push_req  = (cur_status[7:4] == 4'hF) || CHANNEL_MASK[cur_status[3:0]];
              push_d1   = rx_byte;
              push_len  = 2'd2;
              state_nxt = (cur_status[7:4] == 4'hF) ? IDLE : WAIT_D1;
            end
          end
          WAIT_D2: begin
            push_req  = (cur_status[7:4] == 4'hF) || CHANNEL_MASK[cur_status[3:0]];
            push_d1   = data1_q;
            push_d2   = rx_byte;
            push_len  = 2'd3;
            state_nxt = (cur_status[7:4] == 4'hF) ? IDLE : WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  // Parser state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur_status <= 8'h00;
      data1_q    <= 8'h00;
      need2      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_status <= cur_status_nxt;
      data1_q    <= data1_nxt;
      need2      <= need2_nxt;
    end
  end

  assign msg_valid = (fifo_count != '0);
  assign pop       = msg_valid && msg_ready;
  // a full FIFO still takes the new message if the head leaves this cycle
  assign push_ok   = push_req && ((fifo_count != CW'(FIFO_DEPTH)) || pop);
  assign {msg_status, msg_data1, msg_data2, msg_len} = mem[rd_ptr];

  // Message FIFO storage, pointers, occupancy and overflow pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= push_req && !push_ok;
      if (push_ok) begin
        mem[wr_ptr] <= {push_status, push_d1, push_d2, push_len};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push_ok && pop) fifo_count <= fifo_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb_midi_msg_parser: directed byte streams with hand-computed messages
// pushed into an expected queue; a monitor compares each popped message.
module tb_midi_msg_parser;

  typedef struct packed {
    logic [7:0] s;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] len;
  } msg_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       msg_valid;
  logic       msg_ready = 1'b0;
  logic [7:0] msg_status, msg_data1, msg_data2;
  logic [1:0] msg_len;
  logic [2:0] fifo_count;
  logic       overflow;

  msg_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   ov_cnt = 0;

  // channels 0 and 5 enabled, channel 1 filtered
  midi_msg_parser #(.FIFO_DEPTH(4), .CHANNEL_MASK(16'h0021)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_status(msg_status),
    .msg_data1(msg_data1), .msg_data2(msg_data2), .msg_len(msg_len),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    total_cnt++;
    if (got == want) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic expect_msg(input logic [7:0] s, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [1:0] len);
    msg_t m;
    m.s = s; m.d1 = d1; m.d2 = d2; m.len = len;
    exp_q.push_back(m);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every accepted head message against the queue
  always @(negedge clk) begin
    msg_t got, want;
    if (reset) begin
      if (overflow) ov_cnt++;
      if (msg_valid && msg_ready) begin
        got = {msg_status, msg_data1, msg_data2, msg_len};
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_msg: got %h %h %h len%0d expected none",
                   got.s, got.d1, got.d2, got.len);
        end else begin
          want = exp_q.pop_front();
          if (got == want) pass_cnt++;
          else $display("FAIL msg: got %h %h %h len%0d expected %h %h %h len%0d",
                        got.s, got.d1, got.d2, got.len, want.s, want.d1, want.d2, want.len);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_msg_valid", msg_valid, 0);
    chk("rst_fields", {msg_status, msg_data1, msg_data2, 6'(msg_len)}, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    msg_ready = 1'b1;
    idle(2);

    // running status
    expect_msg(8'h90, 8'h3C, 8'h64, 2'd3);
    expect_msg(8'h90, 8'h3E, 8'h50, 2'd3);
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h50);
    // one-data-byte channel message with running status
    expect_msg(8'hC5, 8'h07, 8'h00, 2'd2);
    expect_msg(8'hC5, 8'h09, 8'h00, 2'd2);
    send(8'hC5); send(8'h07); send(8'h09);
    // real-time byte inside a message
`ifdef MIDI_PARSER_REALTIME_EN
    expect_msg(8'hF8, 8'h00, 8'h00, 2'd1);
`endif
    expect_msg(8'h90, 8'h3C, 8'h64, 2'd3);
    send(8'h90); send(8'hF8); send(8'h3C); send(8'h64);
    // real-time byte while waiting for the second data byte
`ifdef MIDI_PARSER_REALTIME_EN
    expect_msg(8'hFF, 8'h00, 8'h00, 2'd1);
`endif
    expect_msg(8'h90, 8'h3C, 8'h64, 2'd3);
    send(8'h90); send(8'h3C); send(8'hFF); send(8'h64);
    // SysEx and orphan data byte produce nothing
    expect_msg(8'h80, 8'h3C, 8'h00, 2'd3);
    send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h3C);
    send(8'h80); send(8'h3C); send(8'h00);
    // status byte terminates SysEx and is processed
    expect_msg(8'h90, 8'h3C, 8'h64, 2'd3);
    send(8'hF0); send(8'h01); send(8'h90); send(8'h3C); send(8'h64);
    // channel filter
    expect_msg(8'h90, 8'h40, 8'h7F, 2'd3);
    send(8'h91); send(8'h40); send(8'h7F); send(8'h90); send(8'h40); send(8'h7F);
    // status mid-message aborts partial message
    expect_msg(8'h80, 8'h3C, 8'h00, 2'd3);
    send(8'h90); send(8'h3C); send(8'h80); send(8'h3C); send(8'h00);
    // system common: no running status afterwards
    expect_msg(8'hF2, 8'h01, 8'h02, 2'd3);
    expect_msg(8'hF6, 8'h00, 8'h00, 2'd1);
    expect_msg(8'hF1, 8'h05, 8'h00, 2'd2);
    send(8'hF2); send(8'h01); send(8'h02); send(8'h3C);
    send(8'hF6); send(8'hF1); send(8'h05); send(8'h06);
    idle(6);
    chk("pre_ovf_count", ov_cnt, 0);
    chk("pre_ovf_fifo_count", fifo_count, 0);

    // overflow: five notes into a stalled 4-entry FIFO
    msg_ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_msg(8'h90, 8'h30 + 8'(i), 8'h40, 2'd3);
    send(8'h90);
    for (int i = 0; i < 5; i++) begin
      send(8'h30 + 8'(i)); send(8'h40);
    end
    idle(3);
    chk("full_fifo_count", fifo_count, 4);
    chk("full_msg_valid", msg_valid, 1);
    chk("overflow_pulses", ov_cnt, 1);
    chk("overflow_low", overflow, 0);
    chk("held_head", {msg_status, msg_data1, msg_data2, 6'(msg_len)}, {8'h90, 8'h30, 8'h40, 6'd3});

    msg_ready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || msg_valid); i++) @(posedge clk);
    #1;
    chk("drain_queue_left", exp_q.size(), 0);
    @(negedge clk);
    chk("end_fifo_count", fifo_count, 0);
    chk("end_msg_valid", msg_valid, 0);
    chk("end_overflow_pulses", ov_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Parametrised MIDI message parser and buffer, the successor to the single-message decoder. It consumes the byte stream from the MIDI UART receiver and frames complete messages, handling running status, SysEx skipping, per-channel filtering and real-time bytes interleaved mid-message. Completed messages go into an output FIFO with a valid/ready handshake, so the voice allocator can stall without losing notes.

## Interface
- `FIFO_DEPTH`, default 4: number of message entries; a power of two, ≥2.
- `CHANNEL_MASK`, default 16'hFFFF: bit n=1 enqueues channel-voice messages on channel n; 0 parses and discards them.
- `clk` in 1: system clock; all state is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: one-cycle strobe; `rx_byte` is valid.
- `rx_byte` in 8: received UART byte.
- `msg_valid` out 1: FIFO head holds a message.
- `msg_ready` in 1: consumer accepts the head when `msg_valid` is also 1.
- `msg_status` out 8: status byte of the head message.
- `msg_data1` out 8: first data byte; 0 if the message has none.
- `msg_data2` out 8: second data byte; 0 if the message has none.
- `msg_len` out 2: total message bytes, 1 to 3.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `overflow` out 1: one-cycle pulse when a completed message is dropped because the FIFO is full.

## Operation
- Parser states:
  - IDLE: no running status.
  - WAIT_D1: status held, expecting the first data byte.
  - WAIT_D2: expecting the second data byte.
  - SYSEX: discarding bytes.
- Status 0x80–0xEF:
  - Latch it as running status, then go to WAIT_D1.
  - Expected data bytes: 1 for 0xCn and 0xDn, else 2.
  - A status byte arriving mid-message aborts the partial message.
- Data byte (bit7=0):
  - IDLE: drop.
  - WAIT_D1 with 1 expected: complete the message.
  - WAIT_D1 with 2 expected: store it, go to WAIT_D2.
  - WAIT_D2: complete the message.
  - After completing a channel-voice message, return to WAIT_D1 with running status retained.
- System common messages:
  - 0xF1 and 0xF3 take 1 data byte; 0xF2 takes 2.
  - 0xF6 completes immediately with `msg_len`=1.
  - 0xF4, 0xF5, and 0xF7 outside SysEx are ignored.
  - All of these clear running status.
  - After completion, go to IDLE.
- 0xF0: enter SYSEX and clear running status.
  - Data bytes are discarded.
  - 0xF7 returns to IDLE.
  - Any other non-real-time status leaves SYSEX and is processed normally.
- Real-time bytes 0xF8–0xFF never change parser state, running status or stored data bytes, in any state.
- Filtering: a completed channel-voice message whose mask bit `CHANNEL_MASK[status[3:0]]` is 0 is not pushed.
- FIFO:
  - Push on the edge that samples the completing byte.
  - Pop on `msg_valid && msg_ready`.
  - Push to a full FIFO is accepted if a pop occurs in the same cycle; otherwise the new message is dropped and `overflow` pulses.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- Reset values: `msg_valid`, `msg_status`, `msg_data1`, `msg_data2`, `msg_len`, `fifo_count` and `overflow` are all 0. The parser is in IDLE, running status is cleared and the FIFO is empty. Reset mid-message discards everything.

## Timing
- Accepts one byte per cycle; `rx_valid` may be high on consecutive cycles.
- Latency: when the FIFO is empty, `msg_valid` rises the cycle after the completing `rx_valid`.
- FIFO outputs are registered.
- Message fields hold stable while `msg_valid`=1 and `msg_ready`=0.
- When `msg_valid`=0, message fields are don't-care; they are 0 after reset.
- `fifo_count` updates the cycle after a push or pop; a simultaneous push and pop leaves it unchanged.
- `overflow` is high for exactly one cycle per dropped message.

## Configuration
- `MIDI_PARSER_REALTIME_EN` defined: each real-time byte is pushed as a message with `msg_status` = the byte, `msg_len`=1 and data fields 0. It follows the normal FIFO and overflow rules and is not subject to `CHANNEL_MASK`.
- Not defined: real-time bytes are silently dropped, with parser state still untouched.

## Test plan
- 90 3C 64, then 3E 50 (running status) → two messages {90,3C,64,len3} and {90,3E,50,len3}.
- C5 07, then 09 → {C5,07,00,len2} and {C5,09,00,len2}.
- 90 F8 3C 64 with `MIDI_PARSER_REALTIME_EN` → {F8,00,00,len1}, then {90,3C,64,len3}. Without the macro → only {90,3C,64,len3}.
- F0 7E 01 F7 3C, then 80 3C 00 → SysEx and the orphan data byte 3C produce nothing; {80,3C,00,len3} is output.
- `CHANNEL_MASK`=16'h0001, input 91 40 7F then 90 40 7F → only the channel-0 message is output.
- `FIFO_DEPTH`=4, `msg_ready`=0, five Note-On messages → `fifo_count`=4, one `overflow` pulse on the fifth. Then draining yields the first four in order.
